// File: rtl/arbiter4_rr_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package arbiter4_rr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_GRANT   = 3'b010,
        ST_RELEASE = 3'b100
    } state_t;

    localparam logic [2:0] GRANT_NONE = 3'd0;

    // Encoded owner (k+1) back to a one-hot grant vector; 0 means no grant.
    function automatic logic [3:0] id_to_onehot(input logic [2:0] id);
        case (id)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/arbiter4_rr_encoder4_3.sv
// MSB-first 4-bit priority encoder: bit k set and no higher bit set -> k+1, none -> 0.
module encoder4_3 (
    input  logic [3:0] value,
    output logic [2:0] code
);

    // Highest set bit wins.
    always_comb begin
        if (value[3]) begin
            code = 3'd4;
        end else if (value[2]) begin
            code = 3'd3;
        end else if (value[1]) begin
            code = 3'd2;
        end else if (value[0]) begin
            code = 3'd1;
        end else begin
            code = 3'd0;
        end
    end

endmodule

// File: rtl/arbiter4_rr.sv
// Four-requester round-robin arbiter with grant hold, one dead cycle between
// owners and an optional hold-time timeout.
module arbiter4_rr
    import arbiter4_rr_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [2:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    localparam bit TIMEOUT_EN = (TIMEOUT != 32'd0);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (TIMEOUT == 32'd0) ? '0 : CNT_W'(TIMEOUT - 32'd1);

    state_t           state_r;
    logic [2:0]       ptr_r;
    logic [CNT_W-1:0] hold_cnt_r;

    logic [3:0] mask_s;
    logic [3:0] masked_req_s;
    logic [2:0] masked_code_s;
    logic [2:0] plain_code_s;
    logic [2:0] pick_id_s;
    logic       owner_req_s;
    logic       hold_expired_s;

    // Only requesters strictly below the last owner are eligible first.
    always_comb begin
        case (ptr_r)
            3'd2:    mask_s = 4'b0001;
            3'd3:    mask_s = 4'b0011;
            3'd4:    mask_s = 4'b0111;
            default: mask_s = 4'b0000;
        endcase
    end

    assign masked_req_s = req & mask_s;

    encoder4_3 u_enc_masked (
        .value (masked_req_s),
        .code  (masked_code_s)
    );

    encoder4_3 u_enc_plain (
        .value (req),
        .code  (plain_code_s)
    );

    // Fall back to the unmasked pick to wrap around to bit 3.
    always_comb begin
        if (masked_req_s != 4'b0000) begin
            pick_id_s = masked_code_s;
        end else begin
            pick_id_s = plain_code_s;
        end
    end

    assign owner_req_s    = (req & grant) != 4'b0000;
    assign hold_expired_s = TIMEOUT_EN && (hold_cnt_r == HOLD_LAST);

    // Arbiter state machine; all outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= GRANT_NONE;
            hold_cnt_r <= '0;
            grant      <= 4'b0000;
            grant_id   <= GRANT_NONE;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RELEASE: begin
                    if (req != 4'b0000) begin
                        grant      <= id_to_onehot(pick_id_s);
                        grant_id   <= pick_id_s;
                        hold_cnt_r <= '0;
                        state_r    <= ST_GRANT;
                        busy       <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req_s || hold_expired_s) begin
                        grant    <= 4'b0000;
                        grant_id <= GRANT_NONE;
                        ptr_r    <= grant_id;
                        state_r  <= ST_RELEASE;
                        busy     <= 1'b1;
                        timeout  <= owner_req_s;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    grant    <= 4'b0000;
                    grant_id <= GRANT_NONE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter4_rr.sv
// Directed bench for arbiter4_rr: default, TIMEOUT=4 and TIMEOUT=0 instances.
module tb_arbiter4_rr;

    logic       clk;
    logic       reset_n;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] grant_a, grant_b, grant_c;
    logic [2:0] id_a, id_b, id_c;
    logic       busy_a, busy_b, busy_c;
    logic       to_a, to_b, to_c;

    int n_cmp;
    int n_err;

    arbiter4_rr dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_a), .grant(grant_a),
        .grant_id(id_a), .busy(busy_a), .timeout(to_a)
    );

    arbiter4_rr #(.TIMEOUT(4), .CNT_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .grant(grant_b),
        .grant_id(id_b), .busy(busy_b), .timeout(to_b)
    );

    arbiter4_rr #(.TIMEOUT(0), .CNT_W(8)) dut_c (
        .clk(clk), .reset_n(reset_n), .req(req_c), .grant(grant_c),
        .grant_id(id_c), .busy(busy_c), .timeout(to_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [2:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [8:0] obs(input logic [1:0] sel);
        case (sel)
            2'd0:    return {grant_a, id_a, busy_a, to_a};
            2'd1:    return {grant_b, id_b, busy_b, to_b};
            default: return {grant_c, id_c, busy_c, to_c};
        endcase
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {grant,id,busy,to}=%b_%0d_%b_%b, want %b_%0d_%b_%b",
                     name, act[8:5], act[4:2], act[1], act[0],
                     exp[8:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic add(input logic [1:0] sel, input logic rst, input logic [3:0] r,
                       input logic [3:0] g, input logic [2:0] id, input logic b, input logic t);
        tbl.push_back('{sel, rst, r, g, id, b, t});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        req_a   = 4'b0000;
        req_b   = 4'b0000;
        req_c   = 4'b0000;

        // Single requester, then handover.
        add(2'd0, 1'b1, 4'b0100, 4'b0100, 3'd3, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b0100, 4'b0100, 3'd3, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        // First arbitration with all four requesting.
        add(2'd0, 1'b1, 4'b1111, 4'b1000, 3'd4, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1111, 4'b1000, 3'd4, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b0111, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1111, 4'b0100, 3'd3, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1111, 4'b0100, 3'd3, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1011, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1111, 4'b0010, 3'd2, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1111, 4'b0010, 3'd2, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1101, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1111, 4'b0001, 3'd1, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1111, 4'b0001, 3'd1, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1110, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1111, 4'b1000, 3'd4, 1'b1, 1'b0);
        // Pointer and mask: last owner 0010, req 1011 -> 0001, then wrap to 1000.
        add(2'd0, 1'b0, 4'b0010, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b0010, 4'b0010, 3'd2, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1001, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1011, 4'b0001, 3'd1, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1010, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b1011, 4'b1000, 3'd4, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(2'd0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        // TIMEOUT=4: 0001 held with 0100 pending, then fairness back to 0001.
        add(2'd1, 1'b1, 4'b0001, 4'b0001, 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add(2'd1, 1'b0, 4'b0101, 4'b0001, 3'd1, 1'b1, 1'b0);
        add(2'd1, 1'b0, 4'b0101, 4'b0000, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) add(2'd1, 1'b0, 4'b0101, 4'b0100, 3'd3, 1'b1, 1'b0);
        add(2'd1, 1'b0, 4'b0101, 4'b0000, 3'd0, 1'b1, 1'b1);
        add(2'd1, 1'b0, 4'b0101, 4'b0001, 3'd1, 1'b1, 1'b0);

        #1;
        check("reset_a", obs(2'd0), 9'd0);
        check("reset_b", obs(2'd1), 9'd0);
        check("reset_c", obs(2'd2), 9'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) pulse_reset();
            else @(negedge clk);
            case (tbl[i].sel)
                2'd0:    req_a = tbl[i].req;
                2'd1:    req_b = tbl[i].req;
                default: req_c = tbl[i].req;
            endcase
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), obs(tbl[i].sel),
                  {tbl[i].grant, tbl[i].id, tbl[i].busy, tbl[i].to});
        end

        // TIMEOUT=0: grant is never revoked.
        @(negedge clk);
        req_c = 4'b0001;
        @(posedge clk);
        #1;
        check("t0_grant", obs(2'd2), {4'b0001, 3'd1, 1'b1, 1'b0});
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("t0_hold%0d", i), obs(2'd2), {4'b0001, 3'd1, 1'b1, 1'b0});
        end

        // Asynchronous reset in the middle of a grant.
        @(negedge clk);
        req_a = 4'b0010;
        @(posedge clk);
        #1;
        check("pre_reset_grant", obs(2'd0), {4'b0010, 3'd2, 1'b1, 1'b0});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", obs(2'd0), 9'd0);
        @(negedge clk);
        req_a   = 4'b0011;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_grant", obs(2'd0), {4'b0010, 3'd2, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
